// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states, response sources.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_RDID = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        RESP,
        IGNORE
    } state_t;

    // Where RESP takes each byte it shifts out.
    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_ID,
        SRC_STATUS
    } src_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Read port between the responder and its synchronous byte memory.
// Latency: mem_rdata is valid exactly one clk after mem_req.
// Backpressure: none; the memory must always answer on time.
//   master: responder side (drives mem_req/mem_addr, receives mem_rdata)
//   slave : memory side
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_rdata);
endinterface

// File: rtl/spi_pin_sync.sv
// Brings the three SPI pins into the clk domain and produces registered edge strobes.
// Latency: 3 clk from pin change to strobe; levels are delayed to line up with strobes.
// Backpressure: none.
//   in : clk, reset (sync, active low), cs_b_pin, sck_pin, mosi_pin
//   out: cs_b_lvl, mosi_lvl, sck_rise, sck_fall, cs_rise, cs_fall
module spi_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic cs_b_pin,
    input  logic sck_pin,
    input  logic mosi_pin,
    output logic cs_b_lvl,
    output logic mosi_lvl,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);
    // [0],[1] are the synchronizer pair, [2] is the previous value for edge detect.
    logic [2:0] cs_sr;
    logic [2:0] sck_sr;
    logic [2:0] mosi_sr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // CS chain resets to "selected" so that a CS already low when reset
            // lifts never looks like a fresh falling edge.
            cs_sr    <= 3'b000;
            sck_sr   <= 3'b111;
            mosi_sr  <= 3'b000;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            cs_sr    <= {cs_sr[1:0], cs_b_pin};
            sck_sr   <= {sck_sr[1:0], sck_pin};
            mosi_sr  <= {mosi_sr[1:0], mosi_pin};
            sck_rise <= sck_sr[1] & ~sck_sr[2];
            sck_fall <= ~sck_sr[1] & sck_sr[2];
            cs_rise  <= cs_sr[1] & ~cs_sr[2];
            cs_fall  <= ~cs_sr[1] & cs_sr[2];
        end
    end

    assign cs_b_lvl = cs_sr[2];
    assign mosi_lvl = mosi_sr[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-3 target answering READ (03), RDSR (05) and RDID (9F) from a byte memory.
// Latency: MISO updates 4 clk after sck fall; first mem_req 1 clk after last address bit.
// Backpressure: none; the SPI master paces everything, memory answers in one clk.
//   SPI  : spi_cs_b, spi_sck, spi_mosi in; spi_miso, spi_miso_oe out
//   mem  : spi_flash_responder_if.master (mem_req, mem_addr, mem_rdata)
//   info : cmd_valid pulse, cmd_opcode held, busy while CS low
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs_b,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    spi_flash_responder_if.master mem,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_opcode,
    output logic                  busy
);

    logic cs_b_lvl, mosi_lvl, sck_rise, sck_fall, cs_rise, cs_fall;

    spi_pin_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .cs_b_pin (spi_cs_b),
        .sck_pin  (spi_sck),
        .mosi_pin (spi_mosi),
        .cs_b_lvl (cs_b_lvl),
        .mosi_lvl (mosi_lvl),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    state_t            state_q, state_d;
    src_t              src_q, src_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;   // address byte count, then ID byte index
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        pf_q, pf_d;               // prefetched memory byte
    logic              pf_pend_q;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_opcode_q, cmd_opcode_d;
    logic              busy_q, busy_d;
    // Set once CS has been seen high after reset; only then is a CS fall trusted.
    logic              armed_q, armed_d;

    logic [7:0]        rx_byte;
    logic              byte_done;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        byte_idx_d   = byte_idx_q;
        tx_d         = tx_q;
        pf_d         = pf_pend_q ? mem.mem_rdata : pf_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        armed_d      = armed_q | cs_b_lvl;
        busy_d       = armed_q & ~cs_b_lvl;
        rx_byte      = {rx_q[6:0], mosi_lvl};
        byte_done    = 1'b0;

        if (cs_rise) begin
            // Deselect beats any coincident sck edge: drop the partial byte.
            state_d   = IDLE;
            tx_d      = 8'hFF;
            bit_cnt_d = 3'd0;
        end else begin
            if (state_q != IDLE && sck_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                byte_done = (bit_cnt_q == 3'd7);
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_d   = OPCODE;
                        bit_cnt_d = 3'd0;
                        tx_d      = 8'hFF;
                    end
                end
                OPCODE: begin
                    if (byte_done) begin
                        cmd_valid_d  = 1'b1;
                        cmd_opcode_d = rx_byte;
                        byte_idx_d   = 2'd0;
                        case (rx_byte)
                            OP_READ: state_d = ADDR;
                            OP_RDID: begin
                                state_d = RESP;
                                src_d   = SRC_ID;
                            end
                            OP_RDSR: begin
                                state_d = RESP;
                                src_d   = SRC_STATUS;
                            end
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        // Shift address bytes straight into mem_addr; high bytes fall
                        // off the top when ADDR_W < 24.
                        mem_addr_d = (mem_addr_q << 8) | ADDR_W'(rx_byte);
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd2) begin
                            mem_req_d  = 1'b1;
                            state_d    = RESP;
                            src_d      = SRC_MEM;
                            byte_idx_d = 2'd0;
                        end
                    end
                end
                RESP: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            case (src_q)
                                SRC_MEM: begin
                                    // Load the prefetched byte and fetch the following one.
                                    tx_d       = pf_q;
                                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                                    mem_req_d  = 1'b1;
                                end
                                SRC_ID: begin
                                    case (byte_idx_q)
                                        2'd0:    tx_d = JEDEC_ID[23:16];
                                        2'd1:    tx_d = JEDEC_ID[15:8];
                                        2'd2:    tx_d = JEDEC_ID[7:0];
                                        default: tx_d = 8'hFF;
                                    endcase
                                    if (byte_idx_q != 2'd3) begin
                                        byte_idx_d = byte_idx_q + 2'd1;
                                    end
                                end
                                default: tx_d = STATUS;
                            endcase
                        end else begin
                            tx_d = {tx_q[6:0], 1'b1};
                        end
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            src_q        <= SRC_MEM;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            byte_idx_q   <= 2'd0;
            tx_q         <= 8'hFF;
            pf_q         <= 8'h00;
            pf_pend_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= 8'h00;
            busy_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            byte_idx_q   <= byte_idx_d;
            tx_q         <= tx_d;
            pf_q         <= pf_d;
            pf_pend_q    <= mem_req_q;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            busy_q       <= busy_d;
            armed_q      <= armed_d;
        end
    end

    assign spi_miso     = tx_q[7];
    assign spi_miso_oe  = (state_q == RESP);
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_opcode   = cmd_opcode_q;
    assign busy         = busy_q;

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI target that answers a minimal serial-flash command set, i.e. the device end of the bootloader's SPI master link. It samples the master's `spi_sck`, `spi_cs_b` and `spi_mosi` in the `clk` domain, decodes opcodes and addresses, and streams read data fetched from a synchronous byte memory back on `spi_miso`. It serves as the flash model in bridge simulations and as a flash emulator on FPGA targets without a physical SPI part.

## Interface
- `ADDR_W`, 24: memory address width (at most 24); the address wraps at 2^ADDR_W.
- `JEDEC_ID`, 24'hEF4016: bytes returned MSB-first for opcode 0x9F.
- `STATUS`, 8'h00: byte returned, repeated, for opcode 0x05.

- `clk` input 1: sole clock.
- `reset` input 1: reset, synchronous, active-low (0 = reset).
- `spi_cs_b` input 1: chip select, active low, asynchronous to `clk`.
- `spi_sck` input 1: SPI clock, mode 3 (idles high), asynchronous to `clk`.
- `spi_mosi` input 1: master data out.
- `spi_miso` output 1: target data out.
- `spi_miso_oe` output 1: MISO drive enable; high only while in a response phase.
- `mem_req` output 1: one-cycle read strobe.
- `mem_addr` output ADDR_W: read address, valid while `mem_req` is high.
- `mem_rdata` input 8: read data, valid exactly one cycle after `mem_req`.
- `cmd_valid` output 1: one-cycle pulse when an opcode byte completes.
- `cmd_opcode` output 8: last decoded opcode, held until the next one.
- `busy` output 1: high while `spi_cs_b` (synchronized) is low.

## Operation
- Inputs pass through 2-FF synchronizers, then edge detection. A sck rising edge samples MOSI; a sck falling edge shifts MISO. Both are MSB first.
- Reset values: `spi_miso`=1, `spi_miso_oe`=0, `mem_req`=0, `mem_addr`=0, `cmd_valid`=0, `cmd_opcode`=0, `busy`=0. The FSM resets to IDLE and the bit counter to 0.
- 3-bit bit counter increments on each sck rising edge. A byte completes when the counter wraps from 7 to 0.
- State IDLE: waits for a falling edge of `spi_cs_b`, then clears the bit counter and enters OPCODE.
- State OPCODE: on byte completion, pulses `cmd_valid` and latches `cmd_opcode`, then branches:
  - 0x03: enters ADDR.
  - 0x9F: enters RESP with an ID source.
  - 0x05: enters RESP with a STATUS source.
  - Any other opcode: enters IGNORE.
- State ADDR: collects 3 bytes, MSB first. The low ADDR_W bits form the address. On the third byte, issues `mem_req` at that address and enters RESP with a memory source.
- State RESP:
  - Falling edge with bit counter 0: loads the next byte and drives bit 7. Other falling edges shift left.
  - Memory source: the byte loaded on the falling edge is the one prefetched by the previous `mem_req`. The address then increments, wrapping at 2^ADDR_W, and a new `mem_req` issues in the same cycle as the load.
  - ID source: emits `JEDEC_ID`[23:16], [15:8], [7:0], then 0xFF repeated.
  - STATUS source: repeats `STATUS`.
  - MOSI is ignored.
- State IGNORE: consumes bits until CS deasserts; `spi_miso_oe` stays 0.
- CS rising edge in any state: returns to IDLE next cycle, discards the partial byte, sets `spi_miso_oe`=0 and `spi_miso`=1, and issues no further `mem_req`.
- Reset asserted mid-transaction: all state returns to reset values, and the block waits for a fresh CS falling edge even if CS is currently low.

## Timing
- Input-to-edge-detect latency: 3 `clk` cycles.
- The sck high and low phases must each be at least 4 `clk` cycles.
- `spi_miso` changes within 4 `clk` cycles of the sck falling edge and is stable before the next rising edge.
- `mem_rdata` is captured into a prefetch register in the cycle after `mem_req`, always before the next sck falling edge.
- At most one `mem_req` per transmitted byte. The first `mem_req` of a read follows the last address bit's rising edge by 1 cycle.
- Simultaneous CS rise and sck edge: the CS rise wins and the sck edge is ignored.

## Structure
- Package `spi_flash_pkg`: opcode constants (`OP_READ`=0x03, `OP_RDSR`=0x05, `OP_RDID`=0x9F) and the FSM state enum (IDLE, OPCODE, ADDR, RESP, IGNORE) plus the response-source enum.
- Sub-module `spi_pin_sync`: 2-FF synchronizers for three pins and registered rise/fall strobes. It is instantiated once.

## Test plan
- Read: CS low, send 03 00 01 00, clock 3 bytes with memory holding mem[0x100..0x102]=A5,5A,C3 -> MISO returns A5 5A C3; `mem_addr` sequence is 0x100, 0x101, 0x102, 0x103.
- Wrap: ADDR_W=8, READ at 0xFF, clock 2 bytes -> data mem[0xFF], mem[0x00]; `mem_addr` wraps to 0x00.
- JEDEC: send 9F, clock 4 bytes -> EF 40 16 FF; `cmd_valid` pulses once with `cmd_opcode`=0x9F.
- Status and unknown opcode: send 05, clock 2 bytes -> 00 00; send 0xAB then 1 byte -> `spi_miso_oe` stays 0 and `spi_miso`=1.
- Abort: CS high after 4 bits of the second address byte, then a new 9F transaction -> no `mem_req` from the aborted read, and the ID is returned correctly.
- Reset mid-read: drive `reset`=0 for 2 cycles during data byte 2 -> all outputs at reset values; with CS still low, no response until CS toggles.
